// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : round-robin two-port arbiter/sequencer for a single-port RAM
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // requester A (CPU data path)
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              a_ack_o,
  // requester B (loader/debug port)
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              b_ack_o,
  // RAM side
  output logic              ram_ena_o,
  output logic              wena_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_in_o,
  input  logic [DATA_W-1:0] data_out_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q;
  logic                prio_q;   // 0 = A, 1 = B
  logic                owner_q;  // 0 = A, 1 = B
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   a_rdata_q;
  logic [DATA_W-1:0]   b_rdata_q;
  logic                a_ack_q;
  logic                b_ack_q;
  logic                ram_ena_q;
  logic                wena_q;

  logic                grant_d;
  logic                grant_b_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

  // Requests only steer what gets latched at the IDLE edge; they never reach the RAM pins directly.
  always_comb begin
    grant_d     = a_req_i | b_req_i;
    grant_b_d   = b_req_i & (~a_req_i | prio_q);
    sel_we_d    = grant_b_d ? b_we_i    : a_we_i;
    sel_addr_d  = grant_b_d ? b_addr_i  : a_addr_i;
    sel_wdata_d = grant_b_d ? b_wdata_i : a_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      ram_ena_q <= 1'b0;
      wena_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_q   <= grant_b_d;
            we_q      <= sel_we_d;
            addr_q    <= sel_addr_d;
            wdata_q   <= sel_wdata_d;
            ram_ena_q <= 1'b1;
            wena_q    <= sel_we_d;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          // The RAM write (if any) commits on this same edge.
          ram_ena_q <= 1'b0;
          wena_q    <= 1'b0;
          if (!we_q) begin
            if (owner_q) b_rdata_q <= data_out_i;
            else         a_rdata_q <= data_out_i;
          end
          a_ack_q <= ~owner_q;
          b_ack_q <= owner_q;
          state_q <= RESP;
        end
        RESP: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          prio_q  <= ~owner_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;
  assign a_ack_o   = a_ack_q;
  assign b_ack_o   = b_ack_q;
  assign ram_ena_o = ram_ena_q;
  assign wena_o    = wena_q;
  assign addr_o    = addr_q;
  assign data_in_o = wdata_q;
  assign busy_o    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : scoreboard bench for ram_arbiter with a behavioural RAM
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ack, b_ack;
  logic        ram_ena, wena, busy;
  logic [4:0]  addr;
  logic [31:0] data_in, data_out;

  ram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(a_rdata), .a_ack_o(a_ack),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rdata_o(b_rdata), .b_ack_o(b_ack),
    .ram_ena_o(ram_ena), .wena_o(wena), .addr_o(addr), .data_in_o(data_in),
    .data_out_i(data_out), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Behavioural 32x32 RAM: combinational read, write on posedge, no reset.
  logic [31:0] mem [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en)                mem[pl_addr] <= pl_data;
    else if (ram_ena && wena) mem[addr]    <= data_in;
  end
  assign data_out = ram_ena ? mem[addr] : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          errors = 0;
  logic [31:0] model_mem [32];
  logic [31:0] last_rd [2];
  int          start_cyc [2];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          ack_log[$];
  bit          log_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected response whenever an ack appears.
  always @(negedge clk) begin
    logic [31:0] exp;
    int lat;
    if (a_ack) begin
      tests++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_ack_unexpected got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        exp = qa.pop_front();
        if (a_rdata !== exp) begin
          errors++;
          $display("FAIL a_rdata got=%0h exp=%0h (cycle %0d)", a_rdata, exp, cyc);
        end
        lat = cyc - start_cyc[0];
        tests++;
        if (lat < 2 || lat > 5) begin
          errors++;
          $display("FAIL a_latency got=%0d exp=2..5", lat);
        end
      end
      if (log_en) ack_log.push_back(1'b0);
    end
    if (b_ack) begin
      tests++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_ack_unexpected got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        exp = qb.pop_front();
        if (b_rdata !== exp) begin
          errors++;
          $display("FAIL b_rdata got=%0h exp=%0h (cycle %0d)", b_rdata, exp, cyc);
        end
        lat = cyc - start_cyc[1];
        tests++;
        if (lat < 2 || lat > 5) begin
          errors++;
          $display("FAIL b_latency got=%0d exp=2..5", lat);
        end
      end
      if (log_en) ack_log.push_back(1'b1);
    end
  end

  // Called at a negedge; the request is sampled at the next posedge.
  task automatic issue(input bit side, input bit we, input logic [4:0] ad, input logic [31:0] wd);
    logic [31:0] exp;
    if (we) begin
      model_mem[ad] = wd;
      exp = last_rd[side];
    end else begin
      exp = model_mem[ad];
    end
    last_rd[side]   = exp;
    start_cyc[side] = cyc;
    if (!side) begin
      a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
      qa.push_back(exp);
    end else begin
      b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
      qb.push_back(exp);
    end
  endtask

  // Returns one negedge after the ack cycle, with req already dropped.
  task automatic wait_ack(input bit side, output int ack_cyc);
    bit got = 1'b0;
    ack_cyc = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = side ? b_ack : a_ack;
    end
    if (got) ack_cyc = cyc;
    else begin
      tests++;
      errors++;
      $display("FAIL %s_ack_timeout got=0 exp=1", side ? "b" : "a");
    end
    if (!side) a_req = 1'b0;
    else       b_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {60'd0, busy, ram_ena, wena, a_ack | b_ack}, 64'd0);
    chk("rst_rdata", {a_rdata, b_rdata}, 64'd0);
    chk("rst_ram_bus", {27'd0, addr, data_in}, 64'd0);
    rst = 1'b0;
    qa.delete(); qb.delete();
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s;
    logic [31:0] v;
    // Preload the RAM while the arbiter is held in reset.
    @(negedge clk);
    pl_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      v = (i == 3) ? 32'hDEADBEEF : $urandom;
      pl_addr = i[4:0]; pl_data = v; model_mem[i] = v;
      @(negedge clk);
    end
    pl_en = 1'b0;
    do_reset();

    // A read right after reset: access in cycle 1, ack in cycle 2.
    issue(1'b0, 1'b0, 5'd3, 32'h0);
    s = cyc;
    @(negedge clk);
    chk("a1_access_ctrl", {62'd0, ram_ena, wena}, 64'd2);
    chk("a1_access_addr", {59'd0, addr}, 64'd3);
    wait_ack(1'b0, c);
    chk("a1_latency", c - s, 64'd2);
    chk("a1_rdata_hold", a_rdata, 64'hDEADBEEF);

    // B write then B read of address 31.
    issue(1'b1, 1'b1, 5'd31, 32'h12345678);
    @(negedge clk);
    chk("bw_access", {30'd0, ram_ena, wena, addr, data_in}, {30'd0, 2'b11, 5'd31, 32'h12345678});
    wait_ack(1'b1, c);
    issue(1'b1, 1'b0, 5'd31, 32'h0);
    wait_ack(1'b1, c);
    chk("br_rdata", b_rdata, 64'h12345678);
    chk("br_a_unchanged", a_rdata, 64'hDEADBEEF);

    // Simultaneous start then continuous contention, 5 accesses per side.
    do_reset();
    ack_log.delete();
    log_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          int lc;
          if (i == 0) issue(1'b0, 1'b0, 5'd1, 32'h0);
          else issue(1'b0, 1'($urandom_range(1, 0)), 5'($urandom_range(15, 0)), $urandom);
          wait_ack(1'b0, lc);
          if (i == 0) chk("simul_a_ack_cycle", lc - start_cyc[0], 64'd2);
        end
      end
      begin
        for (int i = 0; i < 5; i++) begin
          int lc;
          if (i == 0) issue(1'b1, 1'b0, 5'd2, 32'h0);
          else issue(1'b1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 16)), $urandom);
          wait_ack(1'b1, lc);
          if (i == 0) chk("simul_b_ack_cycle", lc - start_cyc[1], 64'd5);
        end
      end
    join
    log_en = 1'b0;
    chk("contention_ack_count", ack_log.size(), 64'd10);
    for (int i = 0; i < ack_log.size(); i++)
      chk($sformatf("grant_order_%0d", i), {63'd0, ack_log[i]}, {63'd0, i[0]});

    // Reset during the ACCESS cycle of an A write.
    issue(1'b0, 1'b1, 5'd7, 32'hCAFEF00D);
    void'(qa.pop_back());
    @(negedge clk);
    chk("rw_access", {62'd0, ram_ena, wena}, 64'd3);
    rst = 1'b1; a_req = 1'b0;
    @(negedge clk);
    chk("rw_after_rst", {61'd0, busy, ram_ena, a_ack}, 64'd0);
    rst = 1'b0;
    qa.delete(); qb.delete();
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
    issue(1'b0, 1'b0, 5'd7, 32'h0);
    wait_ack(1'b0, c);
    chk("rw_readback", a_rdata, 64'hCAFEF00D);

    // Randomized mixed traffic with idle gaps; sides use disjoint address halves.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int lc;
          repeat ($urandom_range(3, 0)) @(negedge clk);
          issue(1'b0, 1'($urandom_range(1, 0)), 5'($urandom_range(15, 0)), $urandom);
          wait_ack(1'b0, lc);
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          int lc;
          repeat ($urandom_range(3, 0)) @(negedge clk);
          issue(1'b1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 16)), $urandom);
          wait_ack(1'b1, lc);
        end
      end
    join

    // Idle: nothing moves for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ctrl", {62'd0, ram_ena, busy}, 64'd0);
      chk("idle_rdata", {a_rdata, b_rdata}, {last_rd[0], last_rd[1]});
    end
    chk("sb_empty", qa.size() + qb.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
